// File: rtl/dmem_pkg.sv
// Shared constants, FSM encoding and small helpers for the dmem_lsu data-memory unit.
// The CLEAR state exists only when DMEM_ZERO_INIT_EN is defined.
package dmem_pkg;

    localparam int BE_W = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] ROM_ID0 = 32'h1198_7251;
    localparam logic [31:0] ROM_ID1 = 32'h1879_0475;
    localparam logic [31:0] ROM_ID2 = 32'h1025_7233;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
`ifdef DMEM_ZERO_INIT_EN
        ST_RESP  = 2'd2,
        ST_CLEAR = 2'd3
`else
        ST_RESP  = 2'd2
`endif
    } dmem_state_e;

    function automatic logic [31:0] rom_word(input logic [1:0] idx);
        logic [31:0] w;
        case (idx)
            2'd0:    w = ROM_ID0;
            2'd1:    w = ROM_ID1;
            2'd2:    w = ROM_ID2;
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    // Move the addressed lane down to bit 0, then sign- or zero-extend.
    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] lane,
                                             input logic [31:0] word);
        logic [31:0] sh;
        logic [31:0] r;
        sh = word >> {lane, 3'b000};
        case (f3)
            F3_B:    r = {{24{sh[7]}}, sh[7:0]};
            F3_H:    r = {{16{sh[15]}}, sh[15:0]};
            F3_W:    r = sh;
            F3_BU:   r = {24'h00_0000, sh[7:0]};
            F3_HU:   r = {16'h0000, sh[15:0]};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Synchronous single-port RAM, 32-bit words, per-byte write enable, one-cycle registered read.
module dmem_ram
    import dmem_pkg::*;
#(
    parameter int RAM_WORDS = 1024,
    parameter int AW        = $clog2(RAM_WORDS)
) (
    input  logic            clk,
    input  logic [BE_W-1:0] we,
    input  logic [AW-1:0]   addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata
);

    logic [31:0] mem_q [RAM_WORDS];
    logic [31:0] rdata_q;

    // Byte-lane writes and registered read of the addressed word.
    always_ff @(posedge clk) begin
        for (int b = 0; b < BE_W; b++) begin
            if (we[b]) begin
                mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit in front of on-chip RAM plus a read-only ID ROM window.
// Optional macro DMEM_ZERO_INIT_EN: zero the whole RAM after every reset before accepting requests.
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RAM_BASE  = 32'h8000_0000,
    parameter int                RAM_WORDS = 1024,
    parameter logic [ADDR_W-1:0] ROM_BASE  = 32'h0010_0000,
    parameter int                ROM_WORDS = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int              AW       = $clog2(RAM_WORDS);
    localparam logic [ADDR_W:0] RAM_SPAN = (ADDR_W+1)'(4 * RAM_WORDS);
    localparam logic [ADDR_W:0] ROM_SPAN = (ADDR_W+1)'(4 * ROM_WORDS);
`ifdef DMEM_ZERO_INIT_EN
    localparam dmem_state_e RESET_ST  = ST_CLEAR;
    localparam logic        READY_RST = 1'b0;
`else
    localparam dmem_state_e RESET_ST  = ST_IDLE;
    localparam logic        READY_RST = 1'b1;
`endif

    dmem_state_e state_q, state_d;
    logic        ready_q, ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  lane_q, lane_d;
    logic        rom_sel_q, rom_sel_d;
    logic [1:0]  rom_idx_q, rom_idx_d;
`ifdef DMEM_ZERO_INIT_EN
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
`endif

    logic [ADDR_W-1:0] ram_off_s, rom_off_s;
    logic              ram_hit_s, rom_hit_s, f3_ok_s, misal_s, fault_s, accept_s;
    logic [BE_W-1:0]   st_be_s, ram_we_s;
    logic [31:0]       st_wdata_s, ram_wdata_s, ram_rdata_s;
    logic [AW-1:0]     ram_addr_s;

    // Window decode, size/alignment legality and store lane steering.
    always_comb begin
        ram_off_s = req_addr - RAM_BASE;
        rom_off_s = req_addr - ROM_BASE;
        ram_hit_s = (req_addr >= RAM_BASE) && ({1'b0, ram_off_s} < RAM_SPAN);
        rom_hit_s = (req_addr >= ROM_BASE) && ({1'b0, rom_off_s} < ROM_SPAN);
        case (req_funct3)
            F3_B, F3_H, F3_W: f3_ok_s = 1'b1;
            F3_BU, F3_HU:     f3_ok_s = !req_we;
            default:          f3_ok_s = 1'b0;
        endcase
        case (req_funct3[1:0])
            2'b01:   misal_s = req_addr[0];
            2'b10:   misal_s = (req_addr[1:0] != 2'b00);
            default: misal_s = 1'b0;
        endcase
        fault_s = !f3_ok_s || misal_s || !(ram_hit_s || rom_hit_s) || (req_we && rom_hit_s);
        case (req_funct3[1:0])
            2'b00: begin
                st_be_s    = 4'b0001 << req_addr[1:0];
                st_wdata_s = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                st_be_s    = 4'b0011 << req_addr[1:0];
                st_wdata_s = {2{req_wdata[15:0]}};
            end
            default: begin
                st_be_s    = 4'b1111;
                st_wdata_s = req_wdata;
            end
        endcase
    end

    // rst gates acceptance so a request presented during reset is never taken or written.
    assign accept_s = req_valid && ready_q && !rst;

    // Next-state, response and RAM port control.
    always_comb begin
        state_d      = state_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'h0000_0000;
        f3_d         = f3_q;
        lane_d       = lane_q;
        rom_sel_d    = rom_sel_q;
        rom_idx_d    = rom_idx_q;
        ram_we_s     = 4'b0000;
        ram_addr_s   = ram_off_s[AW+1:2];
        ram_wdata_s  = st_wdata_s;
`ifdef DMEM_ZERO_INIT_EN
        clr_cnt_d    = clr_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    f3_d      = req_funct3;
                    lane_d    = req_addr[1:0];
                    rom_sel_d = rom_hit_s;
                    rom_idx_d = rom_off_s[3:2];
                    if (fault_s) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (req_we) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        ram_we_s     = st_be_s;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = load_ext(f3_q, lane_q, rom_sel_q ? rom_word(rom_idx_q) : ram_rdata_s);
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
`ifdef DMEM_ZERO_INIT_EN
            ST_CLEAR: begin
                ram_we_s    = 4'b1111;
                ram_addr_s  = clr_cnt_q;
                ram_wdata_s = 32'h0000_0000;
                clr_cnt_d   = clr_cnt_q + AW'(1);
                if (clr_cnt_q == AW'(RAM_WORDS - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    // State and registered outputs; reset drops any in-flight response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RESET_ST;
            ready_q      <= READY_RST;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0000_0000;
            f3_q         <= 3'b000;
            lane_q       <= 2'b00;
            rom_sel_q    <= 1'b0;
            rom_idx_q    <= 2'b00;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            f3_q         <= f3_d;
            lane_q       <= lane_d;
            rom_sel_q    <= rom_sel_d;
            rom_idx_q    <= rom_idx_d;
        end
    end

`ifdef DMEM_ZERO_INIT_EN
    // Clear counter restarts from word 0 on every reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_cnt_q <= '0;
        end else begin
            clr_cnt_q <= clr_cnt_d;
        end
    end
`endif

    dmem_ram #(
        .RAM_WORDS (RAM_WORDS),
        .AW        (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .addr  (ram_addr_s),
        .wdata (ram_wdata_s),
        .rdata (ram_rdata_s)
    );

    assign req_ready  = ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed self-checking bench for dmem_lsu with hand-computed expectations.
module tb_dmem_lsu;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;

    int n_cmp = 0;
    int n_mis = 0;

`ifdef DMEM_ZERO_INIT_EN
    localparam logic [31:0] POST_RST_W0 = 32'h0000_0000;
`else
    localparam logic [31:0] POST_RST_W0 = 32'h2022_AB18;
`endif

    always #5 clk = ~clk;

    dmem_lsu dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) check("ready_timeout", 32'd0, 32'd1);
    endtask

    // One full transaction; called and returns #1 after a rising edge.
    task automatic xfer(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_data, input logic exp_err);
        int lat;
        int exp_lat;
        wait_ready();
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        exp_lat = (!we && !exp_err) ? 2 : 1;
        check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        check({tag, ".data"}, resp_rdata, exp_data);
        check({tag, ".err"}, {31'd0, resp_err}, {31'd0, exp_err});
        @(posedge clk); #1;
        check({tag, ".pulse"}, {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        logic seen;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.valid", {31'd0, resp_valid}, 32'd0);
        check("rst.data", resp_rdata, 32'd0);
        check("rst.err", {31'd0, resp_err}, 32'd0);
        rst = 1'b0;
`ifndef DMEM_ZERO_INIT_EN
        check("rst.ready", {31'd0, req_ready}, 32'd1);
`endif

        // Word store/load round trip
        xfer("sw0",  1'b1, F3_W, 32'h8000_0000, 32'h2022_1118, 32'h0, 1'b0);
        xfer("lw0",  1'b0, F3_W, 32'h8000_0000, 32'h0, 32'h2022_1118, 1'b0);
        // Sub-word stores and extension
        xfer("sb1",  1'b1, F3_B, 32'h8000_0001, 32'h0000_00AB, 32'h0, 1'b0);
        xfer("lw0b", 1'b0, F3_W, 32'h8000_0000, 32'h0, 32'h2022_AB18, 1'b0);
        xfer("lb1",  1'b0, F3_B, 32'h8000_0001, 32'h0, 32'hFFFF_FFAB, 1'b0);
        xfer("lbu1", 1'b0, F3_BU, 32'h8000_0001, 32'h0, 32'h0000_00AB, 1'b0);
        xfer("lhu2", 1'b0, F3_HU, 32'h8000_0002, 32'h0, 32'h0000_2022, 1'b0);
        xfer("lh0",  1'b0, F3_H, 32'h8000_0000, 32'h0, 32'hFFFF_AB18, 1'b0);
        xfer("sw4",  1'b1, F3_W, 32'h8000_0004, 32'h0102_0304, 32'h0, 1'b0);
        xfer("sh6",  1'b1, F3_H, 32'h8000_0006, 32'h1234_BEEF, 32'h0, 1'b0);
        xfer("lw4",  1'b0, F3_W, 32'h8000_0004, 32'h0, 32'hBEEF_0304, 1'b0);
        xfer("lh6",  1'b0, F3_H, 32'h8000_0006, 32'h0, 32'hFFFF_BEEF, 1'b0);
        // RAM window edges
        xfer("swtop", 1'b1, F3_W, 32'h8000_0FFC, 32'hA5A5_5A5A, 32'h0, 1'b0);
        xfer("lwtop", 1'b0, F3_W, 32'h8000_0FFC, 32'h0, 32'hA5A5_5A5A, 1'b0);
        xfer("lwend", 1'b0, F3_W, 32'h8000_1000, 32'h0, 32'h0, 1'b1);
        xfer("lwbel", 1'b0, F3_W, 32'h7FFF_FFFC, 32'h0, 32'h0, 1'b1);
        // ROM window
        xfer("rom0", 1'b0, F3_W, 32'h0010_0000, 32'h0, 32'h1198_7251, 1'b0);
        xfer("rom1", 1'b0, F3_W, 32'h0010_0004, 32'h0, 32'h1879_0475, 1'b0);
        xfer("rom2", 1'b0, F3_W, 32'h0010_0008, 32'h0, 32'h1025_7233, 1'b0);
        xfer("romsw", 1'b1, F3_W, 32'h0010_0004, 32'hFFFF_FFFF, 32'h0, 1'b1);
        xfer("rom1b", 1'b0, F3_W, 32'h0010_0004, 32'h0, 32'h1879_0475, 1'b0);
        xfer("romlb", 1'b0, F3_B, 32'h0010_0002, 32'h0, 32'hFFFF_FF98, 1'b0);
        xfer("romlh", 1'b0, F3_H, 32'h0010_0006, 32'h0, 32'h0000_1879, 1'b0);
        xfer("romhu", 1'b0, F3_HU, 32'h0010_0008, 32'h0, 32'h0000_7233, 1'b0);
        xfer("romend", 1'b0, F3_W, 32'h0010_000C, 32'h0, 32'h0, 1'b1);
        xfer("rombel", 1'b0, F3_W, 32'h000F_FFFC, 32'h0, 32'h0, 1'b1);
        // Faults leave RAM untouched
        xfer("mislw", 1'b0, F3_W, 32'h8000_0002, 32'h0, 32'h0, 1'b1);
        xfer("mislh", 1'b0, F3_H, 32'h8000_0001, 32'h0, 32'h0, 1'b1);
        xfer("lwnul", 1'b0, F3_W, 32'h0000_0000, 32'h0, 32'h0, 1'b1);
        xfer("f3bad", 1'b0, 3'b011, 32'h8000_0000, 32'h0, 32'h0, 1'b1);
        xfer("sbuerr", 1'b1, F3_BU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b1);
        xfer("swmis", 1'b1, F3_W, 32'h8000_0002, 32'hFFFF_FFFF, 32'h0, 1'b1);
        xfer("shmis", 1'b1, F3_H, 32'h8000_0003, 32'hFFFF_FFFF, 32'h0, 1'b1);
        xfer("lw0c", 1'b0, F3_W, 32'h8000_0000, 32'h0, 32'h2022_AB18, 1'b0);

        // Reset right after a load is accepted drops its response
        wait_ready();
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h8000_0000;
        @(posedge clk); #1;
        req_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        seen = resp_valid;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            seen = seen | resp_valid;
        end
        check("rstmid.noresp", {31'd0, seen}, 32'd0);
`ifndef DMEM_ZERO_INIT_EN
        check("rstmid.ready", {31'd0, req_ready}, 32'd1);
`endif

        // Request coinciding with reset is not accepted
        rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W;
        req_addr = 32'h8000_0000; req_wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        req_valid = 1'b0; rst = 1'b0;
        xfer("postrst", 1'b0, F3_W, 32'h8000_0000, 32'h0, POST_RST_W0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Parametrised successor to the team's word-wide byte-enable data memory.
- Adds a valid/ready request interface with response handshake, RISC-V sub-word load/store sizing with sign/zero extension, and a read-only ID ROM window.
- Detects misaligned, out-of-range and illegal accesses.
- Sits between the core's MEM stage and on-chip SRAM.

Parameters:
- ADDR_W, 32, request address width.
- RAM_BASE, 32'h8000_0000, byte base address of the RAM window.
- RAM_WORDS, 1024, RAM depth in 32-bit words (power of two, ≥ 4).
- ROM_BASE, 32'h0010_0000, byte base address of the read-only ID window.
- ROM_WORDS, 3, number of ROM words.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V size/sign code
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, LSB-aligned
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  load result, extended; 0 for stores and errors
- resp_err  out  1  access fault, qualified by resp_valid

Behaviour:
- Reset: clk is the only clock; rst is synchronous and active-high.
  - On a rst edge: FSM goes to IDLE; resp_valid=0, resp_rdata=0, resp_err=0.
  - req_ready=1 from the first cycle after rst is released, unless the optional feature is enabled.
- Handshake:
  - A request is accepted on a rising edge with req_valid & req_ready.
  - req_ready=1 only in IDLE.
  - Request fields are sampled at acceptance only.
- FSM states: IDLE, LOAD, RESP, CLEAR (CLEAR only with the optional feature).
  - IDLE → RESP on an accepted store or any faulting request.
  - IDLE → LOAD on an accepted legal load.
  - LOAD → RESP unconditionally; the synchronous RAM/ROM read data is captured here.
  - RESP → IDLE. resp_valid=1 only while in RESP.
- Latency:
  - Store: resp_valid 1 cycle after acceptance.
  - Legal load: resp_valid 2 cycles after acceptance.
  - Error: resp_valid 1 cycle after acceptance.
  - Throughput: one request per 2 cycles (store/error) or 3 cycles (load).
- funct3 decode:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code sets resp_err.
- Alignment:
  - Halfword requires addr[0]=0.
  - Word requires addr[1:0]=0.
  - A violation sets resp_err.
- Address decode:
  - RAM hit when RAM_BASE ≤ addr < RAM_BASE + 4*RAM_WORDS.
  - ROM hit when ROM_BASE ≤ addr < ROM_BASE + 4*ROM_WORDS.
  - Neither window hit sets resp_err.
  - A store to ROM sets resp_err.
- Stores:
  - Byte enables: SB = 4'b0001 << addr[1:0]; SH = 4'b0011 << addr[1:0]; SW = 4'b1111.
  - Write data is replicated across lanes.
  - The RAM is written on the acceptance edge.
  - A faulting store writes nothing.
- Loads:
  - The selected lane is shifted to bit 0.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- ROM contents, words 0..2: 32'h11987251, 32'h18790475, 32'h10257233.
- Reset mid-operation:
  - An in-flight response is dropped and no resp_valid is issued.
  - A store already accepted stays committed.
- Simultaneous rst and req_valid: rst wins and the request is not accepted.

Optional Feature:
- Macro: DMEM_ZERO_INIT_EN.
- When defined:
  - Reset enters CLEAR; a word counter zeroes RAM words 0..RAM_WORDS-1 at one word per cycle.
  - req_ready=0 throughout CLEAR.
  - After the last word, the FSM goes to IDLE.
  - rst during CLEAR restarts the counter at 0.
- When undefined:
  - RAM contents are unaffected by reset.
  - The CLEAR state and counter are absent.

Decomposition:
- Shared package dmem_pkg:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - FSM state encoding.
  - ROM ID word constants.
  - Byte-enable width constant.
- Sub-module dmem_ram:
  - Synchronous single-port RAM with 4-bit byte write enable.
  - Parametrised by RAM_WORDS.
  - One-cycle registered read.
- Top level holds decode, FSM, alignment/extension logic and the ROM mux.

Test Plan:
1. SW 0x20221118 @0x80000000, then LW @0x80000000 → store resp 1 cycle after accept with err=0; load resp_rdata=0x20221118 2 cycles after accept.
2. SB wdata 0x000000AB @0x80000001, then LW @0x80000000 → 0x2022AB18; LB @0x80000001 → 0xFFFFFFAB; LBU → 0x000000AB; LHU @0x80000002 → 0x00002022.
3. LW @0x00100000, 0x00100004, 0x00100008 → 0x11987251, 0x18790475, 0x10257233; SW @0x00100004 → resp_err=1, and a subsequent read still returns 0x18790475.
4. LW @0x80000002, LH @0x80000001, LW @0x00000000, funct3=011 → each resp_err=1 with resp_rdata=0; RAM unchanged.
5. Accept LW, assert rst on the next edge → no resp_valid, req_ready=1 after release (feature off).
6. DMEM_ZERO_INIT_EN with RAM_WORDS=16: prefill, then reset → req_ready low for 16 cycles, after which LW at any address → 0.
